// File: rtl/md_pkg.sv
// md_pkg: op and state encodings plus the iteration-counter width for the multiply/divide unit.
package md_pkg;
   localparam int MD_WIDTH = 32;

   typedef enum logic [1:0] {
      MD_MULT  = 2'b00,
      MD_MULTU = 2'b01,
      MD_DIV   = 2'b10,
      MD_DIVU  = 2'b11
   } md_op_e;

   typedef enum logic [1:0] {
      S_IDLE = 2'b00,
      S_CALC = 2'b01,
      S_FIX  = 2'b10
   } md_state_e;

   function automatic int cnt_width(input int w);
      return $clog2(w);
   endfunction

   localparam int MD_CNT_W = cnt_width(MD_WIDTH);
endpackage

// File: rtl/md_step.sv
// md_step: one radix-2 iteration; shift-add multiply step or restoring-divide step.
module md_step import md_pkg::*; #(
   parameter int WIDTH = MD_WIDTH
) (
   input  logic             i_is_div,
   input  logic [WIDTH-1:0] i_acc,
   input  logic [WIDTH-1:0] i_q,
   input  logic [WIDTH-1:0] i_b,
   output logic [WIDTH-1:0] o_acc,
   output logic [WIDTH-1:0] o_q
);
   logic [WIDTH:0]   w_sum;
   logic [WIDTH:0]   w_sh;
   logic [WIDTH-1:0] w_diff;
   logic             w_ok;

   // The true difference is below the divisor when it is kept, so WIDTH bits suffice.
   always_comb begin
      w_sum  = {1'b0, i_acc} + (i_q[0] ? {1'b0, i_b} : '0);
      w_sh   = {i_acc, i_q[WIDTH-1]};
      w_ok   = w_sh >= {1'b0, i_b};
      w_diff = w_sh[WIDTH-1:0] - i_b;
      o_acc  = i_is_div ? (w_ok ? w_diff : w_sh[WIDTH-1:0]) : w_sum[WIDTH:1];
      o_q    = i_is_div ? {i_q[WIDTH-2:0], w_ok} : {w_sum[0], i_q[WIDTH-1:1]};
   end
endmodule

// File: rtl/md_unit.sv
// md_unit: iterative MULT/MULTU/DIV/DIVU unit owning HI/LO; WIDTH-step CALC then a sign-fix cycle.
// Optional MD_ABORT_EN adds i_abort, which cancels an op in flight without touching HI/LO.
module md_unit import md_pkg::*; #(
   parameter int WIDTH = MD_WIDTH
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_start,
   input  logic [1:0]       i_op,
   input  logic [WIDTH-1:0] i_a,
   input  logic [WIDTH-1:0] i_b,
   input  logic             i_hi_we,
   input  logic             i_lo_we,
   input  logic [WIDTH-1:0] i_wdata,
`ifdef MD_ABORT_EN
   input  logic             i_abort,
`endif
   output logic             o_busy,
   output logic             o_done,
   output logic             o_div_by_zero,
   output logic [WIDTH-1:0] o_hi,
   output logic [WIDTH-1:0] o_lo
);
   localparam int CW = cnt_width(WIDTH);

   md_state_e          r_state;
   logic [CW-1:0]      r_cnt;
   logic [WIDTH-1:0]   r_acc, r_q, r_b, r_hi, r_lo;
   logic               r_is_div, r_neg_q, r_neg_r, r_dbz, r_busy, r_done, r_dbz_o;
   logic [WIDTH-1:0]   w_acc, w_q, w_quo, w_rem;
   logic [2*WIDTH-1:0] w_prod;
   logic               w_div, w_dbz, w_sa;

   md_step #(.WIDTH(WIDTH)) u_step (
      .i_is_div (r_is_div),
      .i_acc    (r_acc),
      .i_q      (r_q),
      .i_b      (r_b),
      .o_acc    (w_acc),
      .o_q      (w_q)
   );

   // Divide by zero runs unsigned on raw A so the datapath itself yields hi=A, lo=all-ones.
   always_comb begin
      w_div  = (i_op == MD_DIV) || (i_op == MD_DIVU);
      w_dbz  = w_div && (i_b == '0);
      w_sa   = ((i_op == MD_MULT) || (i_op == MD_DIV)) && !w_dbz;
      w_prod = r_neg_q ? -{r_acc, r_q} : {r_acc, r_q};
      w_quo  = r_neg_q ? -r_q : r_q;
      w_rem  = r_neg_r ? -r_acc : r_acc;
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_state  <= S_IDLE;
         r_cnt    <= '0;
         r_acc    <= '0;
         r_q      <= '0;
         r_b      <= '0;
         r_hi     <= '0;
         r_lo     <= '0;
         r_is_div <= 1'b0;
         r_neg_q  <= 1'b0;
         r_neg_r  <= 1'b0;
         r_dbz    <= 1'b0;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
         r_dbz_o  <= 1'b0;
      end
`ifdef MD_ABORT_EN
      else if (i_abort && r_busy) begin
         r_state <= S_IDLE;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_dbz_o <= 1'b0;
      end
`endif
      else begin
         r_done  <= 1'b0;
         r_dbz_o <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (i_hi_we) r_hi <= i_wdata;
               if (i_lo_we) r_lo <= i_wdata;
               if (i_start) begin
                  r_state  <= S_CALC;
                  r_busy   <= 1'b1;
                  r_cnt    <= '0;
                  r_acc    <= '0;
                  r_q      <= (w_sa && i_a[WIDTH-1]) ? -i_a : i_a;
                  r_b      <= (w_sa && i_b[WIDTH-1]) ? -i_b : i_b;
                  r_is_div <= w_div;
                  r_neg_q  <= w_sa && (i_a[WIDTH-1] ^ i_b[WIDTH-1]);
                  r_neg_r  <= w_sa && i_a[WIDTH-1] && w_div;
                  r_dbz    <= w_dbz;
               end
            end
            S_CALC: begin
               r_acc <= w_acc;
               r_q   <= w_q;
               r_cnt <= r_cnt + CW'(1);
               if (r_cnt == CW'(WIDTH - 1)) r_state <= S_FIX;
            end
            S_FIX: begin
               {r_hi, r_lo} <= r_is_div ? {w_rem, w_quo} : w_prod;
               r_done       <= 1'b1;
               r_dbz_o      <= r_dbz;
               r_busy       <= 1'b0;
               r_state      <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign o_busy        = r_busy;
   assign o_done        = r_done;
   assign o_div_by_zero = r_dbz_o;
   assign o_hi          = r_hi;
   assign o_lo          = r_lo;
endmodule

// File: tb/tb_md_unit.sv
// tb_md_unit: randomized and directed checks of md_unit against an arithmetic reference model.
// Build with MD_ABORT_EN defined to also exercise the abort port.
module tb_md_unit;
   logic        i_clk = 1'b0, i_rst_n = 1'b0, i_start = 1'b0, i_hi_we = 1'b0, i_lo_we = 1'b0;
   logic [1:0]  i_op = 2'b00;
   logic [31:0] i_a = '0, i_b = '0, i_wdata = '0;
   logic        o_busy, o_done, o_div_by_zero;
   logic [31:0] o_hi, o_lo;
`ifdef MD_ABORT_EN
   logic        i_abort = 1'b0;
`endif
   int checks = 0, errors = 0;

   md_unit dut (
      .i_clk(i_clk), .i_rst_n(i_rst_n), .i_start(i_start), .i_op(i_op), .i_a(i_a), .i_b(i_b),
      .i_hi_we(i_hi_we), .i_lo_we(i_lo_we), .i_wdata(i_wdata),
`ifdef MD_ABORT_EN
      .i_abort(i_abort),
`endif
      .o_busy(o_busy), .o_done(o_done), .o_div_by_zero(o_div_by_zero), .o_hi(o_hi), .o_lo(o_lo)
   );

   always #5 i_clk = ~i_clk;

   function automatic logic [63:0] ref_md(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
      longint sa, sb;
      logic [63:0] ua, ub;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      ua = {32'd0, a};
      ub = {32'd0, b};
      case (op)
         2'b00: return 64'(sa * sb);
         2'b01: return ua * ub;
         2'b10: begin
            if (b == 0) return {a, 32'hFFFFFFFF};
            return {32'(sa % sb), 32'(sa / sb)};
         end
         default: begin
            if (b == 0) return {a, 32'hFFFFFFFF};
            return {32'(ua % ub), 32'(ua / ub)};
         end
      endcase
   endfunction

   task automatic tick();
      @(posedge i_clk);
      #1;
   endtask

   task automatic launch(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
      i_start = 1'b1; i_op = op; i_a = a; i_b = b;
      tick();
      i_start = 1'b0;
   endtask

   task automatic wait_done(output int lat, output int bc);
      lat = -1;
      bc = int'(o_busy);
      for (int k = 1; k <= 40; k++) begin
         tick();
         if (o_done) begin lat = k; break; end
         bc += int'(o_busy);
      end
   endtask

   task automatic test_reset();
      i_rst_n = 1'b0;
      tick(); tick();
      i_rst_n = 1'b1;
      checks++;
      if ({o_busy, o_done, o_div_by_zero, o_hi, o_lo} !== 67'd0) begin
         errors++;
         $display("FAIL reset: got busy=%b done=%b dbz=%b hi=%h lo=%h, expected all zero", o_busy, o_done, o_div_by_zero, o_hi, o_lo);
      end
   endtask

   typedef struct { logic [1:0] op; logic [31:0] a, b, hi, lo; logic dbz; } vec_t;

   task automatic test_directed();
      vec_t v[5];
      int lat, bc;
      v[0] = '{2'b00, 32'hFFFFFFFF, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0};
      v[1] = '{2'b01, 32'hFFFFFFFF, 32'd2, 32'h00000001, 32'hFFFFFFFE, 1'b0};
      v[2] = '{2'b10, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0};
      v[3] = '{2'b11, 32'd7, 32'd0, 32'd7, 32'hFFFFFFFF, 1'b1};
      v[4] = '{2'b10, 32'h80000000, 32'hFFFFFFFF, 32'd0, 32'h80000000, 1'b0};
      foreach (v[i]) begin
         launch(v[i].op, v[i].a, v[i].b);
         wait_done(lat, bc);
         checks++;
         if ({lat, o_hi, o_lo, o_div_by_zero} !== {33, v[i].hi, v[i].lo, v[i].dbz}) begin
            errors++;
            $display("FAIL directed[%0d]: got lat=%0d hi=%h lo=%h dbz=%b, expected lat=33 hi=%h lo=%h dbz=%b",
                     i, lat, o_hi, o_lo, o_div_by_zero, v[i].hi, v[i].lo, v[i].dbz);
         end
      end
   endtask

   task automatic test_random();
      int lat, bc;
      logic [1:0] op;
      logic [31:0] a, b;
      logic [63:0] exp;
      for (int n = 0; n < 24; n++) begin
         op = 2'($urandom_range(0, 3));
         a = $urandom;
         b = $urandom;
         case ($urandom_range(0, 7))
            0: b = 32'd0;
            1: b = $urandom_range(1, 15);
            2: begin a = 32'h80000000; b = 32'hFFFFFFFF; end
            3: b = -32'($urandom_range(1, 15));
            default: ;
         endcase
         exp = ref_md(op, a, b);
         launch(op, a, b);
         wait_done(lat, bc);
         checks++;
         if ({lat, bc, o_hi, o_lo, o_div_by_zero} !== {33, 33, exp, op[1] && b == 0}) begin
            errors++;
            $display("FAIL random op=%0d a=%h b=%h: got lat=%0d busy=%0d hi=%h lo=%h dbz=%b, expected lat=33 busy=33 hi=%h lo=%h dbz=%b",
                     op, a, b, lat, bc, o_hi, o_lo, o_div_by_zero, exp[63:32], exp[31:0], op[1] && b == 0);
         end
      end
   endtask

   task automatic test_busy_guards();
      int bc, lat;
      logic [63:0] exp;
      exp = ref_md(2'b10, 32'd1000, 32'd7);
      launch(2'b10, 32'd1000, 32'd7);
      bc = int'(o_busy);
      lat = -1;
      for (int k = 1; k <= 40; k++) begin
         if (k == 10) begin
            i_start = 1'b1; i_op = 2'b01; i_a = 32'd3; i_b = 32'd3; i_hi_we = 1'b1; i_wdata = 32'h1234;
         end
         tick();
         i_start = 1'b0; i_hi_we = 1'b0;
         if (o_done) begin lat = k; break; end
         bc += int'(o_busy);
      end
      checks++;
      if ({lat, bc, o_hi, o_lo} !== {33, 33, exp}) begin
         errors++;
         $display("FAIL busy_guard: got lat=%0d busy=%0d hi=%h lo=%h, expected lat=33 busy=33 hi=%h lo=%h",
                  lat, bc, o_hi, o_lo, exp[63:32], exp[31:0]);
      end
      tick();
      checks++;
      if ({o_busy, o_done} !== 2'b00) begin
         errors++;
         $display("FAIL busy_guard_noqueue: got busy=%b done=%b, expected 0 0", o_busy, o_done);
      end
   endtask

   task automatic test_mt();
      int lat, bc;
      i_hi_we = 1'b1; i_wdata = 32'hDEADBEEF;
      tick();
      i_hi_we = 1'b0; i_lo_we = 1'b1; i_wdata = 32'hCAFEF00D;
      tick();
      i_lo_we = 1'b0;
      checks++;
      if ({o_hi, o_lo} !== {32'hDEADBEEF, 32'hCAFEF00D}) begin
         errors++;
         $display("FAIL mthi_mtlo: got hi=%h lo=%h, expected hi=deadbeef lo=cafef00d", o_hi, o_lo);
      end
      i_hi_we = 1'b1; i_wdata = 32'h77;
      launch(2'b01, 32'd5, 32'd6);
      i_hi_we = 1'b0;
      checks++;
      if ({o_busy, o_hi} !== {1'b1, 32'h77}) begin
         errors++;
         $display("FAIL start_with_write: got busy=%b hi=%h, expected busy=1 hi=00000077", o_busy, o_hi);
      end
      wait_done(lat, bc);
      checks++;
      if ({lat, o_hi, o_lo} !== {33, 32'd0, 32'd30}) begin
         errors++;
         $display("FAIL start_with_write_result: got lat=%0d hi=%h lo=%h, expected lat=33 hi=0 lo=1e", lat, o_hi, o_lo);
      end
   endtask

   task automatic test_back_to_back();
      int lat, bc;
      logic [63:0] exp;
      exp = ref_md(2'b00, 32'hFFFFFFF3, 32'd11);
      launch(2'b11, 32'd100, 32'd9);
      wait_done(lat, bc);
      launch(2'b00, 32'hFFFFFFF3, 32'd11);
      checks++;
      if (o_busy !== 1'b1) begin
         errors++;
         $display("FAIL back_to_back_accept: got busy=%b, expected 1", o_busy);
      end
      wait_done(lat, bc);
      checks++;
      if ({lat, o_hi, o_lo} !== {33, exp}) begin
         errors++;
         $display("FAIL back_to_back_result: got lat=%0d hi=%h lo=%h, expected lat=33 hi=%h lo=%h", lat, o_hi, o_lo, exp[63:32], exp[31:0]);
      end
   endtask

   task automatic test_reset_mid_op();
      int dones = 0;
      i_hi_we = 1'b1; i_lo_we = 1'b1; i_wdata = 32'h5A5A5A5A;
      tick();
      i_hi_we = 1'b0; i_lo_we = 1'b0;
      launch(2'b00, 32'd12345, 32'd678);
      for (int k = 1; k < 15; k++) tick();
      i_rst_n = 1'b0;
      tick();
      i_rst_n = 1'b1;
      checks++;
      if ({o_busy, o_hi, o_lo} !== 65'd0) begin
         errors++;
         $display("FAIL reset_mid_op: got busy=%b hi=%h lo=%h, expected all zero", o_busy, o_hi, o_lo);
      end
      for (int k = 0; k < 40; k++) begin
         tick();
         dones += int'(o_done);
      end
      checks++;
      if (dones !== 0) begin
         errors++;
         $display("FAIL reset_mid_op_done: got %0d done pulses, expected 0", dones);
      end
   endtask

`ifdef MD_ABORT_EN
   task automatic test_abort();
      int dones = 0;
      i_hi_we = 1'b1; i_wdata = 32'hA;
      tick();
      i_hi_we = 1'b0; i_lo_we = 1'b1; i_wdata = 32'hB;
      tick();
      i_lo_we = 1'b0;
      launch(2'b00, 32'd99, 32'd77);
      for (int k = 1; k < 5; k++) tick();
      i_abort = 1'b1;
      tick();
      i_abort = 1'b0;
      checks++;
      if ({o_busy, o_hi, o_lo} !== {1'b0, 32'hA, 32'hB}) begin
         errors++;
         $display("FAIL abort: got busy=%b hi=%h lo=%h, expected busy=0 hi=a lo=b", o_busy, o_hi, o_lo);
      end
      for (int k = 0; k < 40; k++) begin
         tick();
         dones += int'(o_done);
      end
      checks++;
      if (dones !== 0) begin
         errors++;
         $display("FAIL abort_done: got %0d done pulses, expected 0", dones);
      end
   endtask
`endif

   initial begin
      test_reset();
      test_directed();
      test_random();
      test_busy_guards();
      test_mt();
      test_back_to_back();
      test_reset_mid_op();
`ifdef MD_ABORT_EN
      test_abort();
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
